// File: rtl/s_pipe_pkg.sv
// Shared constants and helpers for the s_pipe gated-select valid/ready pipeline.
package s_pipe_pkg;

   localparam int          N_DEF         = 8;
   localparam int          SEL_W_DEF     = 2;
   localparam int          DEPTH_DEF     = 2;
   localparam logic [31:0] GATE_MASK_DEF = 32'h0000_0002;

   function automatic int ch_of(input int sel_w);
      return 1 << sel_w;
   endfunction

   function automatic int occ_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // One select bit: mask=1 ORs the operands, mask=0 ANDs them.
   function automatic logic gate_bit(input logic m, input logic a, input logic b);
      return m ? (a | b) : (a & b);
   endfunction

endpackage

// File: rtl/s_pipe_stage.sv
// One pipeline stage: valid flag plus data register, loaded from its source or emptied on move.
module s_pipe_stage #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load,
   input  logic         move,
   input  logic [N-1:0] src,
   output logic [N-1:0] data,
   output logic         valid
);

   always_ff @(posedge clk) begin
      if (clr) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         if (load)      valid <= 1'b1;
         else if (move) valid <= 1'b0;
         if (load)      data  <= src;
      end
   end

endmodule

// File: rtl/s_pipe.sv
// Gated channel select feeding a DEPTH-stage valid/ready pipeline with bubble collapse.
// Optional occupancy counter output occ when S_PIPE_OCC_EN is defined.
module s_pipe
   import s_pipe_pkg::*;
#(
   parameter int               N         = N_DEF,
   parameter int               SEL_W     = SEL_W_DEF,
   parameter int               DEPTH     = DEPTH_DEF,
   parameter logic [SEL_W-1:0] GATE_MASK = GATE_MASK_DEF[SEL_W-1:0]
) (
   input  logic                         clk,
   input  logic                         clr,
   input  logic [ch_of(SEL_W)*N-1:0]    d,
   input  logic [SEL_W-1:0]             a,
   input  logic [SEL_W-1:0]             b,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [N-1:0]                 out_data,
   output logic                         out_valid,
   input  logic                         out_ready
`ifdef S_PIPE_OCC_EN
   ,
   output logic [occ_w(DEPTH)-1:0]      occ
`endif
);

   logic [SEL_W-1:0]          sel;
   logic [N-1:0]              mux;
   logic [DEPTH-1:0]          v, mv, ld;
   logic [DEPTH-1:0][N-1:0]   r, src;

   always_comb begin
      sel = '0;
      for (int i = 0; i < SEL_W; i++) sel[i] = gate_bit(GATE_MASK[i], a[i], b[i]);
   end

   assign mux = d[sel*N +: N];

   // Move chain resolves from the head backwards so a draining head frees the whole pipe in one cycle.
   always_comb begin
      mv = '0;
      mv[DEPTH-1] = v[DEPTH-1] & out_ready;
      for (int i = DEPTH-2; i >= 0; i--) mv[i] = v[i] & (!v[i+1] | mv[i+1]);
   end

   assign in_ready = !clr & (!v[0] | mv[0]);

   // A stage loads exactly when its upstream neighbour moves into it.
   always_comb begin
      ld     = '0;
      src    = '0;
      ld[0]  = in_valid & in_ready;
      src[0] = mux;
      for (int i = 1; i < DEPTH; i++) begin
         ld[i]  = mv[i-1];
         src[i] = r[i-1];
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      s_pipe_stage #(.N(N)) u_stage (
         .clk   (clk),
         .clr   (clr),
         .load  (ld[g]),
         .move  (mv[g]),
         .src   (src[g]),
         .data  (r[g]),
         .valid (v[g])
      );
   end

   assign out_data  = r[DEPTH-1];
   assign out_valid = v[DEPTH-1];

`ifdef S_PIPE_OCC_EN
   localparam int OCC_W = occ_w(DEPTH);
   logic acc, drain;

   assign acc   = in_valid & in_ready;
   assign drain = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (clr)                occ <= '0;
      else if (acc && !drain) occ <= occ + OCC_W'(1);
      else if (drain && !acc) occ <= occ - OCC_W'(1);
   end
`endif

endmodule

// File: tb/tb_s_pipe.sv
// Directed bench for s_pipe: DEPTH=3 main instance plus a DEPTH=1 instance, occ checked when S_PIPE_OCC_EN is set.
module tb_s_pipe;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] d = {8'h44, 8'h33, 8'h22, 8'h11};
   logic [1:0]  a, b, a1, b1;
   logic        iv, iv1, or0, or1;
   logic        ir0, ov0, ir1, ov1;
   logic [7:0]  od0, od1;
`ifdef S_PIPE_OCC_EN
   logic [1:0]  occ0;
   logic        occ1;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   // a/b pairs and the channel each one selects with GATE_MASK=2'b10
   logic [1:0] va   [5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
   logic [1:0] vb   [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01};
   logic [7:0] vexp [5] = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h44};

   always #5 clk = ~clk;

   s_pipe #(.N(8), .SEL_W(2), .DEPTH(3), .GATE_MASK(2'b10)) u_dut (
      .clk(clk), .clr(clr), .d(d), .a(a), .b(b),
      .in_valid(iv), .in_ready(ir0), .out_data(od0), .out_valid(ov0), .out_ready(or0)
`ifdef S_PIPE_OCC_EN
      , .occ(occ0)
`endif
   );

   s_pipe #(.N(8), .SEL_W(2), .DEPTH(1), .GATE_MASK(2'b10)) u_dut1 (
      .clk(clk), .clr(clr), .d(d), .a(a1), .b(b1),
      .in_valid(iv1), .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(or1)
`ifdef S_PIPE_OCC_EN
      , .occ(occ1)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_occ(input string tag, input int exp);
`ifdef S_PIPE_OCC_EN
      chk(tag, 32'(occ0), 32'(exp));
`endif
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int k);
      a = va[k];
      b = vb[k];
   endtask

   initial begin
      logic [7:0] stall_idx [5] = '{8'd0, 8'd2, 8'd3, 8'd4, 8'd4};
      logic       stall_rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      clr = 1'b1; a = '0; b = '0; iv = 1'b0; or0 = 1'b0;
      a1 = '0; b1 = '0; iv1 = 1'b0; or1 = 1'b0;
      cyc; cyc;
      chk("rst_ov", 32'(ov0), 0);
      chk("rst_od", 32'(od0), 0);
      chk("rst_ir", 32'(ir0), 0);
      chk("rst_ov1", 32'(ov1), 0);
      chk_occ("rst_occ", 0);
      clr = 1'b0;
      #1 chk("post_rst_ir", 32'(ir0), 1);

      // gating vectors back-to-back, out_ready=1
      or0 = 1'b1;
      for (int t = 0; t < 7; t++) begin
         if (t < 5) begin
            put(t); iv = 1'b1;
            #1 chk("gate_ir", 32'(ir0), 1);
         end else iv = 1'b0;
         cyc;
         if (t >= 2) begin
            chk("gate_ov", 32'(ov0), 1);
            chk("gate_od", 32'(od0), 32'(vexp[t-2]));
         end else chk("gate_lat", 32'(ov0), 0);
      end
      cyc;
      chk("gate_empty", 32'(ov0), 0);

      // stall: five offers, three accepted, head holds 11
      or0 = 1'b0;
      for (int t = 0; t < 5; t++) begin
         put(int'(stall_idx[t])); iv = 1'b1;
         #1 chk("stall_ir", 32'(ir0), 32'(stall_rdy[t]));
         cyc;
         if (t >= 2) begin
            chk("stall_ov", 32'(ov0), 1);
            chk("stall_od", 32'(od0), 32'h11);
         end
      end
      iv = 1'b0;
      chk_occ("stall_occ", 3);
      or0 = 1'b1;
      #1 chk("unstall_ir", 32'(ir0), 1);
      chk("drain0", 32'(od0), 32'h11);
      cyc; chk("drain1", 32'(od0), 32'h22);
      cyc; chk("drain2", 32'(od0), 32'h33);
      cyc; chk("drain_empty", 32'(ov0), 0);

      // full pipe with simultaneous drain and accept
      or0 = 1'b0; iv = 1'b1;
      put(0); cyc; put(2); cyc; put(3); cyc;
      chk_occ("full_occ", 3);
      put(4); or0 = 1'b1;
      #1 chk("full_ir", 32'(ir0), 1);
      cyc;
      iv = 1'b0;
      chk("full_od", 32'(od0), 32'h22);
      chk_occ("full_occ2", 3);
      cyc; chk("full_d1", 32'(od0), 32'h33);
      cyc; chk("full_d2", 32'(od0), 32'h44);
      chk("full_d2v", 32'(ov0), 1);
      cyc; chk("full_empty", 32'(ov0), 0);

      // bubble collapse under stall
      or0 = 1'b0;
      put(2); iv = 1'b1; cyc;
      iv = 1'b0; cyc; cyc;
      put(3); iv = 1'b1; cyc;
      put(4); cyc;
      iv = 1'b0;
      #1 chk("bub_ir", 32'(ir0), 0);
      chk("bub_ov", 32'(ov0), 1);
      chk("bub_od", 32'(od0), 32'h22);
      chk_occ("bub_occ", 3);

      // reset mid-flight with a concurrent offer
      or0 = 1'b1; cyc;
      or0 = 1'b0;
      chk("mid_od", 32'(od0), 32'h33);
      chk_occ("mid_occ", 2);
      clr = 1'b1; put(0); iv = 1'b1;
      #1 chk("clr_ir", 32'(ir0), 0);
      cyc;
      chk("clr_ov", 32'(ov0), 0);
      chk("clr_od", 32'(od0), 0);
      chk_occ("clr_occ", 0);
      clr = 1'b0; put(3); or0 = 1'b1;
      #1 chk("pclr_ir", 32'(ir0), 1);
      cyc; iv = 1'b0;
      chk("pclr_ov1", 32'(ov0), 0);
      cyc; chk("pclr_ov2", 32'(ov0), 0);
      cyc;
      chk("pclr_ov3", 32'(ov0), 1);
      chk("pclr_od", 32'(od0), 32'h33);
      cyc; chk("pclr_empty", 32'(ov0), 0);

      // DEPTH=1 instance
      a1 = 2'b10; b1 = 2'b00; iv1 = 1'b1; or1 = 1'b0;
      cyc;
      chk("d1_ov", 32'(ov1), 1);
      chk("d1_od", 32'(od1), 32'h33);
      a1 = 2'b11; b1 = 2'b01; or1 = 1'b1;
      #1 chk("d1_ir", 32'(ir1), 1);
      cyc;
      chk("d1_od2", 32'(od1), 32'h44);
      a1 = 2'b00; b1 = 2'b00;
      #1 chk("d1_ir2", 32'(ir1), 1);
      cyc;
      chk("d1_od3", 32'(od1), 32'h11);
      chk("d1_ov3", 32'(ov1), 1);
`ifdef S_PIPE_OCC_EN
      chk("d1_occ", 32'(occ1), 1);
`endif
      iv1 = 1'b0;
      cyc;
      chk("d1_empty", 32'(ov1), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
